// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and FSM state type for the conv output packer
package conv_pkg;

    localparam int LEN_IN        = 25;
    localparam int LEN_OUT       = 8;
    localparam int NUM_PER_FMP   = 3721;
    localparam int OUT_SIDE      = 61;
    localparam int WORDS_PER_FMP = 466;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conv_word_fifo.sv
// rtl/conv_word_fifo.sv - first-word-fall-through FIFO of packed 64-bit words plus last flag
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clr                 synchronous flush (pointers back to empty)
//   push, push_data,    write strobe, 64-bit word, last-of-map flag
//   push_last
//   pop                 read strobe (ignored when empty)
//   head_data,          word and flag at the head (valid while !empty)
//   head_last
//   full, empty         occupancy flags
module conv_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        push_last,
    input  logic        pop,
    output logic [63:0] head_data,
    output logic        head_last,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_q][63:0];
    assign head_last = mem[rd_q][64];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= {push_last, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/conv_out_packer.sv
// rtl/conv_out_packer.sv - requantises conv results to 8 bits and packs eight per 64-bit word
//
// Build option: define PACKER_RELU_EN to clamp negative results to 0 (saturate to [0,127]).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_start_conv            run enable; in_cfg_shift sampled when it rises
//   in_cfg_shift[4:0]        requant right-shift amount
//   in_data0/in_data1        signed LEN_IN-bit results of one beat (in_data0 first)
//   in_writeCtl              beat strobe
//   in_end_conv              conv-finished level
//   out_word/out_valid/      packed output word stream, handshaken with in_ready
//   out_last/in_ready
//   out_done                 every word of the run has left the FIFO
//   out_overflow             sticky: FIFO overflow or map cut short
//   out_map_idx[5:0]         index of the map currently being packed
module conv_out_packer
    import conv_pkg::*;
#(
    parameter int LEN_IN      = conv_pkg::LEN_IN,
    parameter int NUM_PER_FMP = conv_pkg::NUM_PER_FMP,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_start_conv,
    input  logic [4:0]               in_cfg_shift,
    input  logic signed [LEN_IN-1:0] in_data0,
    input  logic signed [LEN_IN-1:0] in_data1,
    input  logic                     in_writeCtl,
    input  logic                     in_end_conv,
    output logic [63:0]              out_word,
    output logic                     out_valid,
    input  logic                     in_ready,
    output logic                     out_last,
    output logic                     out_done,
    output logic                     out_overflow,
    output logic [5:0]               out_map_idx
);

    // Beat index that carries the odd, final result of a map.
    localparam int LAST_BEAT = NUM_PER_FMP / 2;
    localparam int BW        = $clog2(LAST_BEAT + 1);

    localparam logic signed [LEN_IN:0] SAT_HI = (LEN_IN+1)'(127);
    localparam logic signed [LEN_IN:0] SAT_LO = (LEN_IN+1)'(-128);

    // Round-half-up, arithmetic shift, saturate. Shifts of LEN_IN or more always
    // yield 0 for any input, and are forced so the rounding constant cannot wrap.
    function automatic logic [LEN_OUT-1:0] requant(input logic signed [LEN_IN-1:0] x,
                                                   input logic [4:0] s);
        logic signed [LEN_IN:0] ext;
        logic        [LEN_IN:0] rnd;
        logic signed [LEN_IN:0] sum;
        logic signed [LEN_IN:0] shifted;
        logic [LEN_OUT-1:0]     res;
        ext = {x[LEN_IN-1], x};
        rnd = '0;
        if (s != 5'd0) begin
            rnd = (LEN_IN+1)'(1) << (s - 5'd1);
        end
        sum     = ext + $signed(rnd);
        shifted = sum >>> s;
        if (int'(s) >= LEN_IN) begin
            shifted = '0;
        end
`ifdef PACKER_RELU_EN
        if (shifted[LEN_IN]) begin
            res = '0;
        end else if (shifted > SAT_HI) begin
            res = 8'h7F;
        end else begin
            res = shifted[LEN_OUT-1:0];
        end
`else
        if (shifted > SAT_HI) begin
            res = 8'h7F;
        end else if (shifted < SAT_LO) begin
            res = 8'h80;
        end else begin
            res = shifted[LEN_OUT-1:0];
        end
`endif
        return res;
    endfunction

    state_t        state_q, state_d;
    logic          start_q;
    logic [4:0]    shift_q;
    logic [BW-1:0] beat_q;
    logic [5:0]    map_q;
    logic          s1_valid_q, s1_last_q;
    logic [7:0]    s1_b0_q, s1_b1_q;
    logic [47:0]   acc_q, acc_d;     // bytes 0..5 of the word being filled
    logic [1:0]    pair_q, pair_d;   // byte pointer / 2
    logic          overflow_q;

    logic          running, abort, beat_fire, last_beat, end_go;
    logic          push, push_last, pop;
    logic [63:0]   push_word;
    logic [63:0]   head_data;
    logic          head_last, fifo_full, fifo_empty;

    assign running   = (state_q == ST_RUN) && in_start_conv;
    assign abort     = (state_q == ST_RUN) && !in_start_conv;
    assign beat_fire = running && in_writeCtl;
    assign last_beat = (beat_q == BW'(LAST_BEAT));
    assign end_go    = running && in_end_conv && !s1_valid_q && !in_writeCtl;
    assign pop       = out_valid && in_ready;

    // Pack stage: the completing byte pair is pushed straight into the FIFO.
    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        push_word = '0;
        acc_d     = acc_q;
        pair_d    = pair_q;
        if (s1_valid_q) begin
            if (s1_last_q) begin
                push      = 1'b1;
                push_last = 1'b1;
                push_word = {56'b0, s1_b0_q};
                acc_d     = '0;
                pair_d    = '0;
            end else if (pair_q == 2'd3) begin
                push      = 1'b1;
                push_word = {s1_b1_q, s1_b0_q, acc_q};
                acc_d     = '0;
                pair_d    = '0;
            end else begin
                case (pair_q)
                    2'd0:    acc_d[15:0]  = {s1_b1_q, s1_b0_q};
                    2'd1:    acc_d[31:16] = {s1_b1_q, s1_b0_q};
                    default: acc_d[47:32] = {s1_b1_q, s1_b0_q};
                endcase
                pair_d = pair_q + 2'd1;
            end
        end else if (end_go && pair_q != 2'd0) begin
            // Map cut short: flush whatever bytes are pending as the final word.
            push      = 1'b1;
            push_last = 1'b1;
            push_word = {16'b0, acc_q};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_start_conv) state_d = ST_RUN;
            ST_RUN:   if (!in_start_conv) state_d = ST_IDLE;
                      else if (end_go) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            default:  state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            shift_q    <= '0;
            beat_q     <= '0;
            map_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_b0_q    <= '0;
            s1_b1_q    <= '0;
            acc_q      <= '0;
            pair_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= in_start_conv;
            if (in_start_conv && !start_q) begin
                shift_q <= in_cfg_shift;
            end
            if (abort) begin
                beat_q     <= '0;
                map_q      <= '0;
                s1_valid_q <= 1'b0;
                acc_q      <= '0;
                pair_q     <= '0;
            end else begin
                s1_valid_q <= beat_fire;
                if (beat_fire) begin
                    s1_b0_q   <= requant(in_data0, shift_q);
                    s1_b1_q   <= requant(in_data1, shift_q);
                    s1_last_q <= last_beat;
                    if (last_beat) begin
                        beat_q <= '0;
                        map_q  <= map_q + 1'b1;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                acc_q  <= acc_d;
                pair_q <= pair_d;
            end
            if ((push && fifo_full && !pop) || (end_go && beat_q != '0)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    conv_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .push      (push),
        .push_data (push_word),
        .push_last (push_last),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid    = !fifo_empty;
    assign out_word     = out_valid ? head_data : '0;
    assign out_last     = out_valid && head_last;
    assign out_done     = (state_q == ST_DONE);
    assign out_overflow = overflow_q;
    assign out_map_idx  = map_q;

endmodule

// File: tb/tb_conv_out_packer.sv
// tb/tb_conv_out_packer.sv - self-checking bench for conv_out_packer
module tb_conv_out_packer;

    localparam int FIFO_DEPTH = 8;
    localparam int LAST_BEAT  = 1860;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_start_conv;
    logic [4:0]  in_cfg_shift;
    logic [24:0] in_data0, in_data1;
    logic        in_writeCtl, in_end_conv, in_ready;
    logic [63:0] out_word;
    logic        out_valid, out_last, out_done, out_overflow;
    logic [5:0]  out_map_idx;

    always #5 clk = ~clk;

    conv_out_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_start_conv(in_start_conv),
        .in_cfg_shift (in_cfg_shift),
        .in_data0     (in_data0),
        .in_data1     (in_data1),
        .in_writeCtl  (in_writeCtl),
        .in_end_conv  (in_end_conv),
        .out_word     (out_word),
        .out_valid    (out_valid),
        .in_ready     (in_ready),
        .out_last     (out_last),
        .out_done     (out_done),
        .out_overflow (out_overflow),
        .out_map_idx  (out_map_idx)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [64:0] exp_q[$];
    logic [7:0]  rbytes[$];
    int          mbeat, mmaps, cur_shift, popped;
    bit          no_drain;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference requant: round half up, floor division by 2^s, then clamp.
    function automatic logic [7:0] ref_rq(input longint x, input int s);
        longint d, v, y;
        if (s == 0) begin
            y = x;
        end else begin
            d = longint'(1) << s;
            v = x + d / 2;
            y = v / d;
            if ((v % d) != 0 && v < 0) y = y - 1;
        end
`ifdef PACKER_RELU_EN
        if (y < 0) y = 0;
`endif
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return 8'(y);
    endfunction

    function automatic logic [24:0] rnd_data();
        logic [24:0] v;
        v = 25'($urandom);
        v = 25'($signed(v) >>> $urandom_range(0, 20));
        return v;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        rbytes.delete();
        mbeat = 0;
        mmaps = 0;
    endtask

    task automatic model_word(input bit last);
        logic [63:0] w;
        w = '0;
        foreach (rbytes[k]) w[8*k +: 8] = rbytes[k];
        rbytes.delete();
        if (!(no_drain && exp_q.size() >= FIFO_DEPTH)) exp_q.push_back({last, w});
    endtask

    task automatic model_beat(input logic [24:0] a, input logic [24:0] b);
        rbytes.push_back(ref_rq($signed(a), cur_shift));
        if (mbeat == LAST_BEAT) begin
            model_word(1'b1);
            mbeat = 0;
            mmaps++;
        end else begin
            rbytes.push_back(ref_rq($signed(b), cur_shift));
            if (rbytes.size() == 8) model_word(1'b0);
            mbeat++;
        end
    endtask

    // One clock: drive at negedge, check the head word against the model, advance.
    task automatic cyc(input bit wc, input logic [24:0] a, input logic [24:0] b,
                       input bit rdy, input bit endc);
        in_writeCtl = wc;
        in_data0    = a;
        in_data1    = b;
        in_ready    = rdy;
        in_end_conv = endc;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(out_valid), 64'd0);
            end else begin
                chk("word", out_word, exp_q[0][63:0]);
                chk("last", 64'(out_last), 64'(exp_q[0][64]));
                if (exp_q[0][64]) chk("last_upper_zero", {8'b0, out_word[63:8]}, 64'd0);
                if (rdy) begin
                    exp_q.delete(0);
                    popped++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [24:0] a, input logic [24:0] b, input bit rdy);
        model_beat(a, b);
        cyc(1'b1, a, b, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        in_start_conv = 1'b0;
        in_writeCtl   = 1'b0;
        in_ready      = 1'b0;
        in_end_conv   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic start_run(input int s);
        in_cfg_shift  = 5'(s);
        cur_shift     = s;
        in_start_conv = 1'b1;
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_word"},  out_word, 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_last"},  64'(out_last), 64'd0);
        chk({tag, "_done"},  64'(out_done), 64'd0);
        chk({tag, "_ovf"},   64'(out_overflow), 64'd0);
        chk({tag, "_map"},   64'(out_map_idx), 64'd0);
    endtask

    initial begin
        logic [7:0] exp_neg;
        no_drain     = 1'b0;
        popped       = 0;
        in_cfg_shift = '0;
        in_data0     = '0;
        in_data1     = '0;
        @(negedge clk);
        do_reset();
        chk_zero_outputs("reset");

        // Four beats of (5,-3), shift 0: word ready exactly two cycles after the 4th beat.
        start_run(0);
        for (int i = 0; i < 4; i++) beat(25'd5, 25'(-3), 1'b0);
        chk("lat_c1_valid", 64'(out_valid), 64'd0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        chk("lat_c2_valid", 64'(out_valid), 64'd1);
        chk("lat_word", out_word, 64'hFD05_FD05_FD05_FD05);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Shift 4: rounding and saturation.
        do_reset();
        start_run(4);
        beat(25'd1000, 25'(-1000), 1'b0);
        beat(25'd5000, 25'd0, 1'b0);
        beat(25'd0, 25'd0, 1'b0);
        beat(25'd0, 25'd0, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef PACKER_RELU_EN
        exp_neg = 8'h00;
`else
        exp_neg = 8'hC2;
`endif
        chk("rq_pos",  64'(out_word[7:0]),   64'h3F);
        chk("rq_neg",  64'(out_word[15:8]),  64'(exp_neg));
        chk("rq_sat",  64'(out_word[23:16]), 64'h7F);

        // Dropping start in RUN discards buffered words; a restart then works.
        in_start_conv = 1'b0;
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        model_clear();
        chk("abort_valid", 64'(out_valid), 64'd0);
        start_run($urandom_range(0, 15));
        for (int i = 0; i < 8; i++) beat(rnd_data(), rnd_data(), 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("abort_restart_drained", 64'(exp_q.size()), 64'd0);

        // No backpressure: the 9th word into a full FIFO is dropped and flagged.
        do_reset();
        start_run($urandom_range(0, 12));
        no_drain = 1'b1;
        for (int i = 0; i < 34; i++) beat(rnd_data(), rnd_data(), 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
        chk("ovf_after8", 64'(out_overflow), 64'd0);
        for (int i = 34; i < 40; i++) beat(rnd_data(), rnd_data(), 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
        chk("ovf_after9", 64'(out_overflow), 64'd1);
        no_drain = 1'b0;
        for (int i = 0; i < 12; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("ovf_drained", 64'(exp_q.size()), 64'd0);
        chk("ovf_empty", 64'(out_valid), 64'd0);

        // End of conv mid-map: partial word flushed with last, overflow flagged.
        do_reset();
        start_run($urandom_range(20, 31));
        for (int i = 0; i < 5; i++) beat(rnd_data(), rnd_data(), 1'b1);
        model_word(1'b1);
        for (int i = 0; i < 20 && !out_done; i++) cyc(1'b0, '0, '0, 1'b1, 1'b1);
        chk("endmid_ovf",  64'(out_overflow), 64'd1);
        chk("endmid_done", 64'(out_done), 64'd1);
        chk("endmid_drained", 64'(exp_q.size()), 64'd0);

        // Reset after 100 beats clears everything, even with beats still arriving.
        do_reset();
        start_run($urandom_range(0, 18));
        for (int i = 0; i < 100; i++) beat(rnd_data(), rnd_data(), 1'b1);
        rst         = 1'b1;
        in_writeCtl = 1'b1;
        in_ready    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("midrst");
        rst           = 1'b0;
        in_writeCtl   = 1'b0;
        in_start_conv = 1'b0;
        model_clear();

        // Two full maps, then end of conv with a 50% ready pattern.
        start_run($urandom_range(0, 18));
        popped = 0;
        for (int i = 0; i <= LAST_BEAT; i++) begin
            if (i == 0) chk("map_idx0", 64'(out_map_idx), 64'd0);
            beat(rnd_data(), rnd_data(), 1'b1);
        end
        chk("map_idx1", 64'(out_map_idx), 64'(mmaps));
        for (int i = 0; i <= LAST_BEAT; i++) beat(rnd_data(), rnd_data(), 1'(i % 2));
        chk("map_idx2", 64'(out_map_idx), 64'd2);
        for (int k = 0; k < 400; k++) begin
            cyc(1'b0, '0, '0, 1'(k % 2), 1'b1);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain_words", 64'(popped), 64'd932);
        chk("done_not_yet", 64'(out_done), 64'd0);
        cyc(1'b0, '0, '0, 1'b1, 1'b1);
        chk("done", 64'(out_done), 64'd1);
        chk("no_ovf", 64'(out_overflow), 64'd0);

        // Beats in DONE are ignored.
        for (int i = 0; i < 4; i++) cyc(1'b1, rnd_data(), rnd_data(), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
        chk("done_ignores_beats", 64'(out_valid), 64'd0);
        chk("done_held", 64'(out_done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
